// File: rtl/multi_toggle_gen.sv
// multi_toggle_gen: CH independent square-wave generators with programmable
// half-period, shared write port and a global phase-align (sync).
// Optional feature macro: COMPLEMENT_OUT_EN (drives out_n = ~out when defined,
// otherwise out_n is tied low).

// One toggle channel: half-period register, counter and output flop.
module multi_toggle_gen_lane #(
  parameter int          CW         = 8,
  parameter logic [CW-1:0] DEFAULT_HP = CW'(20)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          sync_i,
  input  logic          wr_i,
  input  logic [CW-1:0] wr_data_i,
  output logic          out_o
);

  logic [CW-1:0] hp_q, hp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic [CW-1:0] eff_hp;
  logic          term;

  // A programmed half-period of zero behaves like one (toggle every cycle).
  assign eff_hp = (hp_q == '0) ? CW'(1) : hp_q;
  assign term   = (cnt_q == eff_hp - CW'(1));

  // Next-state: sync beats write beats terminal count; en=0 holds.
  always_comb begin
    hp_d  = hp_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (wr_i) hp_d = wr_data_i;
    if (sync_i) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (wr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (term) begin
        cnt_d = '0;
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State flops; reset aborts any period in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_q  <= DEFAULT_HP;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      hp_q  <= hp_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

module multi_toggle_gen #(
  parameter int CH         = 4,
  parameter int CW         = 8,
  parameter int DEFAULT_HP = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic          sync,
  input  logic          wr_en,
  input  logic [3:0]    wr_ch,
  input  logic [CW-1:0] wr_data,
  output logic [CH-1:0] out,
  output logic [CH-1:0] out_n
);

  // Writes with wr_ch >= CH match no lane and are dropped.
  for (genvar i = 0; i < CH; i++) begin : g_lane
    logic wr_sel;
    assign wr_sel = wr_en && (wr_ch == 4'(i));

    multi_toggle_gen_lane #(
      .CW        (CW),
      .DEFAULT_HP(CW'(DEFAULT_HP))
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en[i]),
      .sync_i   (sync),
      .wr_i     (wr_sel),
      .wr_data_i(wr_data),
      .out_o    (out[i])
    );
  end

`ifdef COMPLEMENT_OUT_EN
  assign out_n = ~out;
`else
  assign out_n = '0;
`endif

endmodule

// File: tb/tb_multi_toggle_gen.sv
// Directed table-driven bench for multi_toggle_gen (CH=4, CW=8, DEFAULT_HP=20).
module tb_multi_toggle_gen;

`ifdef COMPLEMENT_OUT_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] en = '0;
  logic       sync = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_ch = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] out, out_n;

  int checks = 0;
  int failures = 0;

  multi_toggle_gen #(.CH(4), .CW(8), .DEFAULT_HP(20)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .out(out), .out_n(out_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] en;
    logic       sync;
    logic       wr_en;
    logic [3:0] wr_ch;
    logic [7:0] wr_data;
    int         ncyc;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(string tag, logic [3:0] e, logic s, logic w,
                              logic [3:0] c, logic [7:0] d, int n, logic [3:0] x);
    vec_t v;
    v.tag = tag; v.en = e; v.sync = s; v.wr_en = w; v.wr_ch = c;
    v.wr_data = d; v.ncyc = n; v.exp = x;
    return v;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [3:0] exp);
    logic [3:0] exp_n;
    exp_n = COMP ? ~exp : 4'h0;
    checks++;
    if (out !== exp) begin
      failures++;
      $display("FAIL %s out=%b expected=%b", nm, out, exp);
    end
    checks++;
    if (out_n !== exp_n) begin
      failures++;
      $display("FAIL %s out_n=%b expected=%b", nm, out_n, exp_n);
    end
  endtask

  task automatic drive(logic [3:0] e, logic s, logic w, logic [3:0] c, logic [7:0] d);
    en = e; sync = s; wr_en = w; wr_ch = c; wr_data = d;
  endtask

  initial begin
    tbl[0]  = mk("ch0_pre_toggle",  4'b0001, 1'b0, 1'b0, 4'd0, 8'd0, 19, 4'b0000);
    tbl[1]  = mk("ch0_toggle1",     4'b0001, 1'b0, 1'b0, 4'd0, 8'd0,  1, 4'b0001);
    tbl[2]  = mk("ch0_hold_hi",     4'b0001, 1'b0, 1'b0, 4'd0, 8'd0, 19, 4'b0001);
    tbl[3]  = mk("ch0_toggle2",     4'b0001, 1'b0, 1'b0, 4'd0, 8'd0,  1, 4'b0000);
    tbl[4]  = mk("ch0_toggle3",     4'b0001, 1'b0, 1'b0, 4'd0, 8'd0, 20, 4'b0001);
    tbl[5]  = mk("wr_ch2_hp3",      4'b0000, 1'b0, 1'b1, 4'd2, 8'd3,  1, 4'b0001);
    tbl[6]  = mk("ch2_pre",         4'b0100, 1'b0, 1'b0, 4'd0, 8'd0,  2, 4'b0001);
    tbl[7]  = mk("ch2_toggle1",     4'b0100, 1'b0, 1'b0, 4'd0, 8'd0,  1, 4'b0101);
    tbl[8]  = mk("ch2_toggle2",     4'b0100, 1'b0, 1'b0, 4'd0, 8'd0,  3, 4'b0001);
    tbl[9]  = mk("ch2_toggle3",     4'b0100, 1'b0, 1'b0, 4'd0, 8'd0,  3, 4'b0101);
    tbl[10] = mk("wr_ch2_hp0",      4'b0100, 1'b0, 1'b1, 4'd2, 8'd0,  1, 4'b0101);
    tbl[11] = mk("ch2_hp0_t1",      4'b0100, 1'b0, 1'b0, 4'd0, 8'd0,  1, 4'b0001);
    tbl[12] = mk("ch2_hp0_t2",      4'b0100, 1'b0, 1'b0, 4'd0, 8'd0,  1, 4'b0101);
    tbl[13] = mk("ch2_hp0_t3",      4'b0100, 1'b0, 1'b0, 4'd0, 8'd0,  1, 4'b0001);
    tbl[14] = mk("wr_ch5_ignored",  4'b0000, 1'b0, 1'b1, 4'd5, 8'd2,  1, 4'b0001);
    tbl[15] = mk("ch1_default_pre", 4'b0010, 1'b0, 1'b0, 4'd0, 8'd0, 19, 4'b0001);
    tbl[16] = mk("ch1_default_tgl", 4'b0010, 1'b0, 1'b0, 4'd0, 8'd0,  1, 4'b0011);
    tbl[17] = mk("mid_period_run",  4'b0111, 1'b0, 1'b0, 4'd0, 8'd0,  5, 4'b0111);
    tbl[18] = mk("sync_with_wr",    4'b0111, 1'b1, 1'b1, 4'd0, 8'd4,  1, 4'b0000);
    tbl[19] = mk("post_sync_pre",   4'b0001, 1'b0, 1'b0, 4'd0, 8'd0,  3, 4'b0000);
    tbl[20] = mk("post_sync_hp4",   4'b0001, 1'b0, 1'b0, 4'd0, 8'd0,  1, 4'b0001);

    // Reset state
    #12;
    chk("reset_state", 4'b0000);
    rst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].sync, tbl[k].wr_en, tbl[k].wr_ch, tbl[k].wr_data);
      step(tbl[k].ncyc);
      chk(tbl[k].tag, tbl[k].exp);
    end

    // Enable dropped mid-period: ch0 back to hp=20, freeze at cnt=10.
    drive(4'b0000, 1'b0, 1'b1, 4'd0, 8'd20);
    step(1);
    chk("wr_ch0_hp20", 4'b0001);
    drive(4'b0001, 1'b0, 1'b0, 4'd0, 8'd0);
    step(10);
    chk("ch0_cnt10", 4'b0001);
    en = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("ch0_frozen", 4'b0001);
    end
    en = 4'b0001;
    step(9);
    chk("ch0_resume_pre", 4'b0001);
    step(1);
    chk("ch0_resume_tgl", 4'b0000);

    // Write to ch1 on its terminal count: no toggle, counter restarts.
    drive(4'b0010, 1'b0, 1'b0, 4'd0, 8'd0);
    step(19);
    chk("ch1_at_term", 4'b0000);
    drive(4'b0010, 1'b0, 1'b1, 4'd1, 8'd5);
    step(1);
    chk("ch1_wr_no_toggle", 4'b0000);
    drive(4'b0010, 1'b0, 1'b0, 4'd0, 8'd0);
    step(4);
    chk("ch1_new_pre", 4'b0000);
    step(1);
    chk("ch1_new_toggle", 4'b0010);

    // Reset asserted mid-period: immediate clear, hp back to default.
    step(2);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_mid", 4'b0000);
    @(posedge clk); #1;
    chk("reset_held", 4'b0000);
    rst = 1'b0;
    en = 4'b1111;
    step(19);
    chk("post_rst_pre", 4'b0000);
    step(1);
    chk("post_rst_hp20", 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_toggle_gen.md
MULTI_TOGGLE_GEN -- requirements
Module: multi_toggle_gen

Interface
REQ-001 SHALL provide parameter CH, default 4, meaning number of independent toggle channels (1..16).
REQ-002 SHALL provide parameter CW, default 8, meaning half-period counter/register width in bits.
REQ-003 SHALL provide parameter DEFAULT_HP, default 20, meaning reset value of every channel's half-period register.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-005 SHALL have port clk, input, 1 bit, meaning rising-edge clock for all state.
REQ-006 SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-007 SHALL have port en, input, CH bits, meaning per-channel run enable.
REQ-008 SHALL have port sync, input, 1 bit, meaning synchronous phase-align of all channels.
REQ-009 SHALL have port wr_en, input, 1 bit, meaning half-period register write strobe.
REQ-010 SHALL have port wr_ch, input, 4 bits, meaning target channel index for the write.
REQ-011 SHALL have port wr_data, input, CW bits, meaning new half-period value in clk cycles.
REQ-012 SHALL have port out, output, CH bits, meaning registered square-wave outputs.
REQ-013 SHALL have port out_n, output, CH bits, meaning complementary outputs (see Configuration).

Function
REQ-014 SHALL keep per channel a half-period register hp[i] (CW bits), a counter cnt[i] (CW bits) and an output flop out[i].
REQ-015 SHALL, when en[i]=1 and cnt[i] != eff_hp-1, increment cnt[i] by 1 each cycle; eff_hp = hp[i], with hp[i]=0 treated as 1.
REQ-016 SHALL, when en[i]=1 and cnt[i] == eff_hp-1, invert out[i] and load cnt[i]=0 in the same cycle; output period = 2*eff_hp cycles, 50% duty.
REQ-017 SHALL, when en[i]=0, hold cnt[i] and out[i] unchanged; re-asserting en resumes counting from the held count.
REQ-018 SHALL, on wr_en=1 with wr_ch < CH, load hp[wr_ch]=wr_data and clear cnt[wr_ch]=0 on the next edge, leaving out[wr_ch] unchanged.
REQ-019 SHALL ignore wr_en when wr_ch >= CH; no state changes.
REQ-020 SHALL give a write priority over a terminal count on the same channel in the same cycle: no toggle, counter cleared.
REQ-021 SHALL, on sync=1, clear every cnt[i] and every out[i] to 0 on the next edge regardless of en or wr_en; hp writes in that cycle still take effect.
REQ-022 SHALL drive out directly from flops (no combinational path from inputs); the first toggle after reset or sync with en held high occurs eff_hp cycles later.
REQ-023 SHALL let channels operate fully independently except for sync and the shared write port.

Reset
REQ-024 SHALL, while rst=1, asynchronously force out=0, every cnt[i]=0 and every hp[i]=DEFAULT_HP.
REQ-025 SHALL abort any count in progress when rst asserts mid-period; after release, counting restarts from 0.
REQ-026 SHALL drive out_n to its reset value (all ones with COMPLEMENT_OUT_EN, all zeros without) during reset.

Configuration
REQ-027 SHALL use macro COMPLEMENT_OUT_EN: when defined, out_n = ~out bitwise (an inverter per channel, no added latency).
REQ-028 SHALL, when COMPLEMENT_OUT_EN is undefined, tie out_n to all zeros and instantiate no complement logic.

Verification (CH=4, CW=8, DEFAULT_HP=20)
REQ-029 SHALL cover: reset release, en=4'b0001 -> out[0] toggles every 20 cycles (period 40), out[3:1]=0.
REQ-030 SHALL cover: write wr_ch=2, wr_data=3, then en[2]=1 -> out[2] period 6; wr_data=0 -> toggles every cycle.
REQ-031 SHALL cover: en[0] dropped at cnt=10 for 5 cycles -> out[0] frozen, next toggle 10 enabled cycles after resume.
REQ-032 SHALL cover: write to channel 1 coincident with its terminal count -> no toggle, new period begins from 0.
REQ-033 SHALL cover: sync pulse with channels mid-period -> all out=0, all cnt=0 next cycle; wr_ch=5 write -> no effect.
REQ-034 SHALL cover: rst asserted mid-period -> immediate out=0, hp=20; out_n=4'hF with COMPLEMENT_OUT_EN, 4'h0 without.
